vq_codebook_cache_mw: RTL and testbench
=======================================

// Module: vq_codebook_cache_mw
// PURPOSE
//  Multi-way cache of VQ texture codebooks for the PVR texture path. Holds NUM_WAYS
//  codebooks of WORDS_PER_CB words. A request (tag, index) returns one codebook word;
//  on a miss it evicts a way, refills the whole codebook from VRAM, then answers.
//  Sits between texture-address generation and the VRAM read arbiter.
// PARAMETERS
//  TAG_WIDTH     12   codebook identifier width (per-polygon texture tag)
//  NUM_WAYS      4    codebooks resident at once (power of 2, 2..16)
//  WORDS_PER_CB  256  words per codebook (power of 2)
//  WORD_WIDTH    64   codebook word width
// PORTS
//  clock        in   1                    system clock
//  reset        in   1                    synchronous, active-high reset
//  cache_clear  in   1                    invalidate all ways
//  req_valid    in   1                    lookup request
//  req_ready    out  1                    request accepted when req_valid&&req_ready
//  req_tag      in   TAG_WIDTH            codebook tag
//  req_index    in   log2(WORDS_PER_CB)   word index within codebook
//  rd_valid     out  1                    rd_data valid (single-cycle pulse)
//  rd_data      out  WORD_WIDTH           codebook word
//  vram_rd      out  1                    refill in progress; VRAM word requested
//  vram_tag     out  TAG_WIDTH            tag being refilled
//  vram_offset  out  log2(WORDS_PER_CB)   word offset being requested
//  vram_valid   in   1                    vram_din valid for vram_offset
//  vram_din     in   WORD_WIDTH           refill data
//  hit_count    out  16                   only with VQ_CB_STATS_EN
//  miss_count   out  16                   only with VQ_CB_STATS_EN
// BEHAVIOUR
//  Reset: state IDLE, all way-valid bits 0, victim ptr 0, req_ready 1, rd_valid 0,
//   vram_rd 0, vram_offset 0, counters 0. Reset mid-refill abandons it cleanly.
//  Tags held in registers (NUM_WAYS x TAG_WIDTH); compare is combinational, all ways.
//  Data in one sync RAM, address {way, index}, 1-cycle read latency.
//  FSM IDLE: req_ready=1. Accepted hit -> RAM read, rd_valid exactly 1 cycle later;
//   back-to-back hits sustain 1 word/cycle. Accepted miss -> latch tag/index,
//   victim=ptr, clear valid[victim], go FILL; req_ready=0 from next cycle.
//  FILL: vram_rd=1, vram_offset=word counter. Each vram_valid writes vram_din to
//   {victim, counter}, counter++. vram_valid with vram_rd=0 is ignored. After word
//   WORDS_PER_CB-1: tag[victim]<=latched tag, valid[victim]<=1 (unless cleared, below),
//   ptr<=ptr+1 (wraps at NUM_WAYS), go REPLAY.
//  REPLAY: RAM read of {victim, latched index}; rd_valid next cycle; go IDLE.
//   Miss-to-rd_valid latency = WORDS_PER_CB VRAM beats + 2 cycles.
//  Replacement: round-robin; invalid ways are not preferred (ptr order only).
//  cache_clear: clears all valid bits same cycle; wins over a simultaneous lookup
//   (that lookup misses). During FILL the refill completes and the request is
//   answered, but the refilled way is left invalid.
//  Duplicate tags cannot arise (refill only on miss); a hit never blocks on FILL.
// CONFIGURATION
//  VQ_CB_STATS_EN defined: hit_count/miss_count count accepted hits/misses,
//   saturate at 16'hFFFF, reset and cache_clear zero them.
//  Undefined: ports absent, no counter logic.
// STRUCTURE
//  Package pvr_cb_pkg: FSM state enum (IDLE/FILL/REPLAY), clog2 helper for
//   index/way widths, default parameter constants.
//  Sub-module vq_cb_data_ram: single-port sync RAM (write-first not required),
//   NUM_WAYS*WORDS_PER_CB x WORD_WIDTH; altsyncram on target, behavioural in sim.
// TESTING
//  1 Cold miss: tag 0x123 idx 5, VRAM returns word n = n*3 -> 256 beats, rd_data=15,
//    way0 valid; then tag 0x123 idx 200 -> hit, rd_data=600 one cycle after accept.
//  2 Fill 5 tags 0x10..0x14 (NUM_WAYS=4) -> 0x14 evicts 0x10; 0x11 hits, 0x10 misses.
//  3 Hit streaming: 8 back-to-back hits idx 0..7 -> 8 consecutive rd_valid cycles.
//  4 cache_clear at FILL beat 100 -> request still answered; next same tag misses.
//  5 reset at FILL beat 50 -> outputs at reset values; same tag then misses, refill
//    restarts at vram_offset 0.
//  6 VQ_CB_STATS_EN: 3 misses + 10 hits -> miss_count=3, hit_count=10; clear -> 0.

Source files
------------

// File: rtl/vq_codebook_cache_mw_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pvr_cb_pkg                                                    |
// | Brief    : Shared types, default sizes and width helper for the VQ       |
// |            codebook cache.                                               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package pvr_cb_pkg;

   // Default geometry of the codebook cache
   localparam int C_TAG_WIDTH    = 12;
   localparam int C_NUM_WAYS     = 4;
   localparam int C_WORDS_PER_CB = 256;
   localparam int C_WORD_WIDTH   = 64;

   // Controller states: waiting for lookups, refilling a way, answering the miss
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_REPLAY = 2'd2
   } cb_state_t;

   // Ceiling log2, used to size index and way fields
   function automatic int f_clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vq_codebook_cache_mw_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vq_codebook_cache_mw_if                                       |
// | Brief    : Lookup, response and VRAM refill signals of the codebook      |
// |            cache. master = texture path / VRAM side, slave = cache.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface vq_codebook_cache_mw_if
   import pvr_cb_pkg::*;
#(
   parameter int TAG_WIDTH    = C_TAG_WIDTH,
   parameter int WORDS_PER_CB = C_WORDS_PER_CB,
   parameter int WORD_WIDTH   = C_WORD_WIDTH
);
   localparam int IDX_WIDTH = f_clog2(WORDS_PER_CB);

   logic                  cache_clear;
   logic                  req_valid;
   logic                  req_ready;
   logic [TAG_WIDTH-1:0]  req_tag;
   logic [IDX_WIDTH-1:0]  req_index;
   logic                  rd_valid;
   logic [WORD_WIDTH-1:0] rd_data;
   logic                  vram_rd;
   logic [TAG_WIDTH-1:0]  vram_tag;
   logic [IDX_WIDTH-1:0]  vram_offset;
   logic                  vram_valid;
   logic [WORD_WIDTH-1:0] vram_din;

   modport master (
      output cache_clear, req_valid, req_tag, req_index, vram_valid, vram_din,
      input  req_ready, rd_valid, rd_data, vram_rd, vram_tag, vram_offset
   );

   modport slave (
      input  cache_clear, req_valid, req_tag, req_index, vram_valid, vram_din,
      output req_ready, rd_valid, rd_data, vram_rd, vram_tag, vram_offset
   );

endinterface
`default_nettype wire

// File: rtl/vq_codebook_cache_mw_data_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vq_cb_data_ram                                                |
// | Brief    : Single-port synchronous RAM holding all resident codebooks,   |
// |            addressed {way, index}. One-cycle read latency; read data on  |
// |            a write cycle is unspecified. Maps onto altsyncram.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module vq_cb_data_ram #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 1024
) (
   input  wire logic                  clock,
   input  wire logic                  i_we,
   input  wire logic [ADDR_WIDTH-1:0] i_addr,
   input  wire logic [DATA_WIDTH-1:0] i_wdata,
   output logic      [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   // Write port and registered read port share one address
   always_ff @(posedge clock) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/vq_codebook_cache_mw.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vq_codebook_cache_mw                                          |
// | Brief    : Multi-way VQ codebook cache. Tags in registers with a         |
// |            parallel compare; data in one sync RAM. A miss evicts the     |
// |            round-robin victim, refills the whole codebook from VRAM and  |
// |            then answers the original request.                            |
// | Options  : VQ_CB_STATS_EN - adds saturating hit/miss counters.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module vq_codebook_cache_mw
   import pvr_cb_pkg::*;
#(
   parameter int TAG_WIDTH    = C_TAG_WIDTH,
   parameter int NUM_WAYS     = C_NUM_WAYS,
   parameter int WORDS_PER_CB = C_WORDS_PER_CB,
   parameter int WORD_WIDTH   = C_WORD_WIDTH
) (
   input  wire logic             clock,
   input  wire logic             reset,
   vq_codebook_cache_mw_if.slave bus
`ifdef VQ_CB_STATS_EN
   ,
   output logic [15:0]           hit_count,
   output logic [15:0]           miss_count
`endif
);

   localparam int C_IDX_W  = f_clog2(WORDS_PER_CB);
   localparam int C_WAY_W  = f_clog2(NUM_WAYS);
   localparam int C_ADDR_W = C_WAY_W + C_IDX_W;
   localparam logic [C_IDX_W-1:0] C_IDX_ONE = 1;
   localparam logic [C_WAY_W-1:0] C_WAY_ONE = 1;

   cb_state_t              r_state;
   logic [TAG_WIDTH-1:0]   r_tag [NUM_WAYS];
   logic [NUM_WAYS-1:0]    r_valid;
   logic [C_WAY_W-1:0]     r_ptr;
   logic [C_WAY_W-1:0]     r_victim;
   logic [TAG_WIDTH-1:0]   r_lat_tag;
   logic [C_IDX_W-1:0]     r_lat_idx;
   logic [C_IDX_W-1:0]     r_cnt;
   logic                   r_req_ready;
   logic                   r_rd_valid;
   logic                   r_vram_rd;
   logic                   r_clr_seen;

   logic [NUM_WAYS-1:0]    w_hit_vec;
   logic                   w_hit;
   logic [C_WAY_W-1:0]     w_hit_way;
   logic                   w_accept;
   logic                   w_acc_hit;
   logic                   w_acc_miss;
   logic                   w_fill_beat;
   logic                   w_last_beat;
   logic                   w_ram_we;
   logic [C_ADDR_W-1:0]    w_ram_addr;
   logic [WORD_WIDTH-1:0]  w_ram_rdata;

   // Parallel tag compare against every way
   generate
      for (genvar g = 0; g < NUM_WAYS; g++) begin : g_cmp
         assign w_hit_vec[g] = r_valid[g] && (r_tag[g] == bus.req_tag);
      end
   endgenerate

   // A clear in the lookup cycle wins, so the lookup is treated as a miss
   assign w_hit       = (|w_hit_vec) && !bus.cache_clear;
   assign w_accept    = bus.req_valid && r_req_ready;
   assign w_acc_hit   = w_accept && w_hit;
   assign w_acc_miss  = w_accept && !w_hit;
   assign w_fill_beat = (r_state == ST_FILL) && r_vram_rd && bus.vram_valid;
   assign w_last_beat = w_fill_beat && (&r_cnt);

   // Encode the matching way; tags are unique so at most one bit is set
   always_comb begin
      w_hit_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (w_hit_vec[w]) begin
            w_hit_way = C_WAY_W'(w);
         end
      end
   end

   // RAM address: hit lookup in IDLE, refill write in FILL, answer read in REPLAY
   always_comb begin
      w_ram_addr = {w_hit_way, bus.req_index};
      w_ram_we   = 1'b0;
      case (r_state)
         ST_FILL: begin
            w_ram_addr = {r_victim, r_cnt};
            w_ram_we   = w_fill_beat;
         end
         ST_REPLAY: begin
            w_ram_addr = {r_victim, r_lat_idx};
         end
         default: begin
         end
      endcase
   end

   // Controller FSM with registered handshake outputs and way bookkeeping
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_valid     <= '0;
         r_ptr       <= '0;
         r_victim    <= '0;
         r_lat_tag   <= '0;
         r_lat_idx   <= '0;
         r_cnt       <= '0;
         r_req_ready <= 1'b1;
         r_rd_valid  <= 1'b0;
         r_vram_rd   <= 1'b0;
         r_clr_seen  <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_acc_hit) begin
                  r_rd_valid <= 1'b1;
               end else if (w_acc_miss) begin
                  r_lat_tag      <= bus.req_tag;
                  r_lat_idx      <= bus.req_index;
                  r_victim       <= r_ptr;
                  r_valid[r_ptr] <= 1'b0;
                  r_cnt          <= '0;
                  r_clr_seen     <= 1'b0;
                  r_req_ready    <= 1'b0;
                  r_vram_rd      <= 1'b1;
                  r_state        <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (bus.cache_clear) begin
                  r_clr_seen <= 1'b1;
               end
               if (w_fill_beat) begin
                  r_cnt <= r_cnt + C_IDX_ONE;
                  if (w_last_beat) begin
                     // A clear seen during the refill leaves the new way invalid
                     r_valid[r_victim] <= !(r_clr_seen || bus.cache_clear);
                     r_ptr             <= r_ptr + C_WAY_ONE;
                     r_vram_rd         <= 1'b0;
                     r_state           <= ST_REPLAY;
                  end
               end
            end
            ST_REPLAY: begin
               r_rd_valid  <= 1'b1;
               r_req_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
         if (bus.cache_clear) begin
            r_valid <= '0;
         end
      end
   end

   // Tag store: the refilled way takes the latched tag on the final beat
   always_ff @(posedge clock) begin
      if (w_last_beat) begin
         r_tag[r_victim] <= r_lat_tag;
      end
   end

   vq_cb_data_ram #(
      .ADDR_WIDTH (C_ADDR_W),
      .DATA_WIDTH (WORD_WIDTH),
      .DEPTH      (NUM_WAYS * WORDS_PER_CB)
   ) u_data_ram (
      .clock   (clock),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (bus.vram_din),
      .o_rdata (w_ram_rdata)
   );

   assign bus.req_ready   = r_req_ready;
   assign bus.rd_valid    = r_rd_valid;
   assign bus.rd_data     = w_ram_rdata;
   assign bus.vram_rd     = r_vram_rd;
   assign bus.vram_tag    = r_lat_tag;
   assign bus.vram_offset = r_cnt;

`ifdef VQ_CB_STATS_EN
   logic [15:0] r_hit_cnt;
   logic [15:0] r_miss_cnt;

   // Saturating counters of accepted hits and misses; clear zeroes them
   always_ff @(posedge clock) begin
      if (reset || bus.cache_clear) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_acc_hit && (r_hit_cnt != 16'hFFFF)) begin
            r_hit_cnt <= r_hit_cnt + 16'd1;
         end
         if (w_acc_miss && (r_miss_cnt != 16'hFFFF)) begin
            r_miss_cnt <= r_miss_cnt + 16'd1;
         end
      end
   end

   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vq_codebook_cache_mw.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vq_codebook_cache_mw                                       |
// | Brief    : Scoreboard bench for the VQ codebook cache: a behavioural     |
// |            cache model predicts hit/miss and data, a VRAM responder      |
// |            serves refills, a monitor checks every response.              |
// | Options  : VQ_CB_STATS_EN - also checks the hit/miss counters.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_vq_codebook_cache_mw;
   import pvr_cb_pkg::*;

   localparam int TAG_W = 12;
   localparam int NW    = 4;
   localparam int WPC   = 256;
   localparam int WW    = 64;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   vq_codebook_cache_mw_if #(.TAG_WIDTH(TAG_W), .WORDS_PER_CB(WPC), .WORD_WIDTH(WW)) cb_if ();

`ifdef VQ_CB_STATS_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   vq_codebook_cache_mw #(
      .TAG_WIDTH    (TAG_W),
      .NUM_WAYS     (NW),
      .WORDS_PER_CB (WPC),
      .WORD_WIDTH   (WW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (cb_if)
`ifdef VQ_CB_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   typedef struct {
      logic [63:0] data;
      bit          miss;
      int          acc_cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          beat = 0;
   int          refills = 0;
   int          refills_seen = 0;
   int          last_beat_cyc = 0;

   // Reference cache: resident tags in round-robin slots
   logic [11:0] m_tag [NW];
   bit          m_valid [NW];
   int          m_ptr = 0;
   logic [11:0] exp_fill_tag = '0;

   always @(posedge clock) cyc <= cyc + 1;

   // VRAM contents: tag 0x123 holds n*3, other tags are offset in the upper half
   function automatic logic [63:0] cb_word(input logic [11:0] tag, input int n);
      logic [11:0] t;
      t = tag ^ 12'h123;
      return {20'd0, t, 32'(n * 3)};
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic model_clear();
      for (int i = 0; i < NW; i++) m_valid[i] = 1'b0;
   endtask

   // Issue one lookup (optionally with a simultaneous clear); entered and left at a negedge
   task automatic send(input logic [11:0] tag, input logic [7:0] idx, output int waited,
                       input bit clr = 1'b0);
      int   w;
      bit   hit;
      exp_t e;
      w = 0;
      cb_if.req_valid   = 1'b1;
      cb_if.req_tag     = tag;
      cb_if.req_index   = idx;
      cb_if.cache_clear = clr;
      while (!cb_if.req_ready && w < 2000) begin
         @(negedge clock);
         w++;
      end
      waited = w;
      if (!cb_if.req_ready) begin
         check("req_ready_timeout", 64'(cb_if.req_ready), 64'd1);
         cb_if.req_valid   = 1'b0;
         cb_if.cache_clear = 1'b0;
         return;
      end
      if (clr) model_clear();
      hit = 1'b0;
      for (int i = 0; i < NW; i++) if (m_valid[i] && m_tag[i] == tag) hit = 1'b1;
      if (!hit) begin
         m_tag[m_ptr]   = tag;
         m_valid[m_ptr] = 1'b1;
         m_ptr          = (m_ptr + 1) % NW;
         exp_fill_tag   = tag;
      end
      e.data    = cb_word(tag, int'(idx));
      e.miss    = !hit;
      e.acc_cyc = cyc + 1;
      sb.push_back(e);
      @(negedge clock);
      cb_if.req_valid   = 1'b0;
      cb_if.cache_clear = 1'b0;
   endtask

   task automatic clear();
      cb_if.cache_clear = 1'b1;
      model_clear();
      @(negedge clock);
      cb_if.cache_clear = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 3000) begin
         @(negedge clock);
         w++;
      end
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
   endtask

   task automatic wait_beat(input int n);
      int w;
      w = 0;
      while (beat < n && w < 3000) begin
         @(negedge clock);
         w++;
      end
      check("refill_reached_beat", 64'(beat >= n), 64'd1);
   endtask

   task automatic do_reset();
      reset             = 1'b1;
      cb_if.req_valid   = 1'b0;
      cb_if.cache_clear = 1'b0;
      sb.delete();
      model_clear();
      m_ptr = 0;
      repeat (2) @(negedge clock);
      check("rst_req_ready", 64'(cb_if.req_ready), 64'd1);
      check("rst_rd_valid", 64'(cb_if.rd_valid), 64'd0);
      check("rst_vram_rd", 64'(cb_if.vram_rd), 64'd0);
      check("rst_vram_offset", 64'(cb_if.vram_offset), 64'd0);
`ifdef VQ_CB_STATS_EN
      check("rst_hit_count", 64'(hit_count), 64'd0);
      check("rst_miss_count", 64'(miss_count), 64'd0);
`endif
      reset = 1'b0;
      @(negedge clock);
   endtask

   // VRAM responder: serves refill beats with random gaps, idles with stray valids
   initial begin
      cb_if.vram_valid = 1'b0;
      cb_if.vram_din   = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            cb_if.vram_valid = 1'b0;
            beat = 0;
         end else if (cb_if.vram_rd) begin
            if ($urandom_range(0, 7) != 0) begin
               check("vram_offset", 64'(cb_if.vram_offset), 64'(beat));
               if (beat == 0) check("vram_tag", 64'(cb_if.vram_tag), 64'(exp_fill_tag));
               cb_if.vram_valid = 1'b1;
               cb_if.vram_din   = cb_word(exp_fill_tag, beat);
               beat++;
               if (beat == WPC) begin
                  beat = 0;
                  refills++;
                  last_beat_cyc = cyc + 1;
               end
            end else begin
               cb_if.vram_valid = 1'b0;
            end
         end else begin
            cb_if.vram_valid = ($urandom_range(0, 15) == 0);
            cb_if.vram_din   = {$urandom, $urandom};
         end
      end
   end

   // Monitor: pops the scoreboard on every response
   initial begin
      exp_t e;
      bit   saw_refill;
      forever begin
         @(negedge clock);
         if (!reset && cb_if.rd_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_rd_valid", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               saw_refill   = (refills != refills_seen);
               refills_seen = refills;
               check("rd_data", cb_if.rd_data, e.data);
               check("miss_refill", 64'(saw_refill), 64'(e.miss));
               check("latency", 64'(cyc), e.miss ? 64'(last_beat_cyc + 1) : 64'(e.acc_cyc));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int tot;
      cb_if.req_valid   = 1'b0;
      cb_if.req_tag     = '0;
      cb_if.req_index   = '0;
      cb_if.cache_clear = 1'b0;
      model_clear();
      @(negedge clock);
      do_reset();

      // Cold miss then hit on the refilled codebook
      send(12'h123, 8'd5, w);
      drain();
      send(12'h123, 8'd200, w);
      drain();

      // Five tags through four ways: the oldest is evicted
      clear();
      for (int t = 'h10; t <= 'h14; t++) send(12'(t), 8'($urandom_range(0, 255)), w);
      send(12'h11, 8'd17, w);
      send(12'h10, 8'd33, w);
      drain();

      // Back-to-back hits without stalls
      tot = 0;
      for (int i = 0; i < 8; i++) begin
         send(12'h14, 8'(i), w);
         tot += w;
      end
      check("stream_stall_cycles", 64'(tot), 64'd0);
      drain();

      // Clear coincident with a lookup forces a miss
      send(12'h14, 8'd1, w, 1'b1);
      drain();

      // Clear during refill: answered, but the way stays invalid
      send(12'h55, 8'd9, w);
      wait_beat(100);
      clear();
      drain();
      send(12'h55, 8'd9, w);
      drain();

      // Reset mid-refill abandons it; refill restarts from offset 0
      send(12'h66, 8'd3, w);
      wait_beat(50);
      do_reset();
      send(12'h66, 8'd3, w);
      drain();

      // Random traffic over a small tag set
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 39) == 0) clear();
         if ($urandom_range(0, 3) == 0) @(negedge clock);
         send(12'h40 + 12'($urandom_range(0, 5)), 8'($urandom_range(0, 255)), w);
      end
      drain();

`ifdef VQ_CB_STATS_EN
      // Counter check: 3 misses then 10 hits, then clear
      do_reset();
      for (int i = 0; i < 3; i++) send(12'h70 + 12'(i), 8'(i), w);
      for (int i = 0; i < 10; i++) send(12'h70 + 12'(i % 3), 8'(i + 20), w);
      drain();
      check("miss_count", 64'(miss_count), 64'd3);
      check("hit_count", 64'(hit_count), 64'd10);
      clear();
      check("miss_count_clr", 64'(miss_count), 64'd0);
      check("hit_count_clr", 64'(hit_count), 64'd0);
`endif

      repeat (3) @(negedge clock);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
